// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

  // Which digit currently owns the display.
  typedef enum logic {
    SLOT1  = 1'b0,
    SLOT10 = 1'b1
  } slot_t;

  // Code that always decodes to an unlit digit; also the snapshot reset value.
  localparam logic [3:0] BLANK_CODE = 4'd15;

  // Lit segment patterns, bit0=a .. bit6=g, indexed by BCD code.
  // Codes 10..15 are not decimal digits and show nothing.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

endpackage

// File: rtl/seg7_decode.sv
// BCD to a..g lit-pattern lookup (active-high, polarity applied by the caller).
// Latency: purely combinational.
// Backpressure: none.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segs
);

  assign segs = SEG_LUT[bcd];

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexes a two-digit BCD value onto one 7-segment bus with per-digit commons.
// Latency: display state computed in a cycle is registered onto the pins on the next edge.
// Backpressure: none; ena=0 freezes the sequencer and blanks the display.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int SLOT_BITS  = 12,
  parameter int GAP_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] digit1,
  input  logic [3:0] digit10,
  input  logic       seg_pol,
  input  logic       com_pol,
  input  logic       lzb,
  output logic [7:0] seg,
  output logic       com1,
  output logic       com10,
  output logic [1:0] com_oe
);

  localparam logic [SLOT_BITS-1:0] GAP_CNT  = SLOT_BITS'(GAP_CYCLES);
  localparam logic [SLOT_BITS-1:0] CNT_LAST = '1;

  slot_t                state, state_nxt;
  logic [SLOT_BITS-1:0] cnt, cnt_nxt, cnt_eff;
  logic                 restart_pend, restart_pend_nxt;
  logic [3:0]           snap1, snap1_nxt, snap10, snap10_nxt;
  logic [3:0]           cur_digit;
  logic [6:0]           dec_segs;
  logic                 gap;
  logic [7:0]           seg_nxt;
  logic                 com1_nxt, com10_nxt;
  logic [1:0]           com_oe_nxt;

  // After an ena-low period the slot restarts from position 0, so the stored
  // count is overridden for the first enabled cycle.
  assign cnt_eff = restart_pend ? '0 : cnt;
  assign gap     = (cnt_eff < GAP_CNT);

  // On the snapshot cycle the live input is used so the value shown equals the
  // value captured, even with a zero-length gap.
  assign cur_digit = (state == SLOT1)
                   ? ((cnt_eff == '0) ? digit1  : snap1)
                   : ((cnt_eff == '0) ? digit10 : snap10);

  seg7_decode u_decode (
    .bcd  (cur_digit),
    .segs (dec_segs)
  );

  // Sequencer: slot timing, slot alternation and per-slot digit snapshots.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    snap1_nxt        = snap1;
    snap10_nxt       = snap10;
    restart_pend_nxt = restart_pend;
    if (!ena) begin
      restart_pend_nxt = 1'b1;
    end else begin
      restart_pend_nxt = 1'b0;
      if (cnt_eff == '0) begin
        if (state == SLOT1) snap1_nxt  = digit1;
        else                snap10_nxt = digit10;
      end
      if (cnt_eff == CNT_LAST) begin
        state_nxt = (state == SLOT1) ? SLOT10 : SLOT1;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt_eff + 1'b1;
      end
    end
  end

  // Display: pick lit pattern and active common, then apply pin polarities.
  always_comb begin
    logic [7:0] lit;
    logic       act1;
    logic       act10;
    lit   = 8'h00;
    act1  = 1'b0;
    act10 = 1'b0;
    if (ena && !gap) begin
      if (state == SLOT1) begin
        act1 = 1'b1;
        lit  = {1'b0, dec_segs};
      end else begin
        // Leading-zero blanking hides the digit but keeps its common driven.
        act10 = 1'b1;
        if (!(lzb && cur_digit == 4'd0)) lit = {1'b0, dec_segs};
      end
    end
    seg_nxt    = lit ^ {8{~seg_pol}};
    com1_nxt   = ~(act1 ^ com_pol);
    com10_nxt  = ~(act10 ^ com_pol);
    com_oe_nxt = ena ? 2'b11 : 2'b00;
  end

  // State, counter, snapshot and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SLOT1;
      cnt          <= '0;
      restart_pend <= 1'b0;
      snap1        <= BLANK_CODE;
      snap10       <= BLANK_CODE;
      seg          <= 8'h00;
      com1         <= 1'b0;
      com10        <= 1'b0;
      com_oe       <= 2'b00;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      restart_pend <= restart_pend_nxt;
      snap1        <= snap1_nxt;
      snap10       <= snap10_nxt;
      seg          <= seg_nxt;
      com1         <= com1_nxt;
      com10        <= com10_nxt;
      com_oe       <= com_oe_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver with short slots (16 cycles, 2-cycle gap).
// Latency: outputs compared 1 time unit after each rising edge against a reference model.
// Backpressure: n/a.
module tb_seg7_mux_driver;

  localparam int SB       = 4;
  localparam int GAP      = 2;
  localparam int SLOT_LEN = 1 << SB;

  logic       clk = 1'b0;
  logic       rst_n, ena, seg_pol, com_pol, lzb;
  logic [3:0] digit1, digit10;
  logic [7:0] seg;
  logic       com1, com10;
  logic [1:0] com_oe;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: slot position and owner as plain integers.
  int         m_pos;
  int         m_slot;
  logic [3:0] m_snap [2];
  bit         m_pend;
  bit         pol_valid;
  logic       pol_q;
  logic [7:0] e_seg;
  logic       e_c1, e_c10;
  logic [1:0] e_oe;

  seg7_mux_driver #(.SLOT_BITS(SB), .GAP_CYCLES(GAP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .digit1  (digit1),
    .digit10 (digit10),
    .seg_pol (seg_pol),
    .com_pol (com_pol),
    .lzb     (lzb),
    .seg     (seg),
    .com1    (com1),
    .com10   (com10),
    .com_oe  (com_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_pattern(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_pos     = 0;
    m_slot    = 0;
    m_snap[0] = 4'd15;
    m_snap[1] = 4'd15;
    m_pend    = 1'b0;
    pol_valid = 1'b0;
    e_seg     = 8'h00;
    e_c1      = 1'b0;
    e_c10     = 1'b0;
    e_oe      = 2'b00;
  endtask

  // What the pins should show after this rising edge, given current inputs.
  task automatic model_edge();
    logic [6:0] lit;
    bit a1, a10;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pol_q     = com_pol;
    pol_valid = 1'b1;
    if (!ena) begin
      e_seg  = {8{~seg_pol}};
      e_c1   = ~com_pol;
      e_c10  = ~com_pol;
      e_oe   = 2'b00;
      m_pend = 1'b1;
      return;
    end
    if (m_pend) begin
      m_pos  = 0;
      m_pend = 1'b0;
    end
    if (m_pos == 0) m_snap[m_slot] = (m_slot == 0) ? digit1 : digit10;
    lit = 7'h00;
    a1  = 1'b0;
    a10 = 1'b0;
    if (m_pos >= GAP) begin
      if (m_slot == 0) begin
        a1  = 1'b1;
        lit = ref_pattern(m_snap[0]);
      end else begin
        a10 = 1'b1;
        lit = (lzb && m_snap[1] == 4'd0) ? 7'h00 : ref_pattern(m_snap[1]);
      end
    end
    e_seg = {1'b0, lit} ^ {8{~seg_pol}};
    e_c1  = a1  ? com_pol : ~com_pol;
    e_c10 = a10 ? com_pol : ~com_pol;
    e_oe  = 2'b11;
    m_pos = m_pos + 1;
    if (m_pos == SLOT_LEN) begin
      m_pos  = 0;
      m_slot = 1 - m_slot;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, got, want);
    end
  endtask

  task automatic compare_model();
    chk("seg",    seg,              e_seg);
    chk("com1",   {7'd0, com1},     {7'd0, e_c1});
    chk("com10",  {7'd0, com10},    {7'd0, e_c10});
    chk("com_oe", {6'd0, com_oe},   {6'd0, e_oe});
    if (rst_n && pol_valid) begin
      total++;
      assert (!(com1 === pol_q && com10 === pol_q)) else begin
        bad++;
        $error("FAIL com_exclusive cyc=%0d: observed com1=%b com10=%b with active level %b",
               cyc, com1, com10, pol_q);
      end
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] s, input logic c1,
                            input logic c10, input logic [1:0] oe);
    chk({tag, ".seg"},    seg,            s);
    chk({tag, ".com1"},   {7'd0, com1},   {7'd0, c1});
    chk({tag, ".com10"},  {7'd0, com10},  {7'd0, c10});
    chk({tag, ".com_oe"}, {6'd0, com_oe}, {6'd0, oe});
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b1;
    digit1  = 4'd7;
    digit10 = 4'd3;
    seg_pol = 1'b1;
    com_pol = 1'b1;
    lzb     = 1'b0;
    model_reset();
    #1;
    expect_out("reset", 8'h00, 1'b0, 1'b0, 2'b00);
    run(2);
    #1 rst_n = 1'b1;

    // 7 / 3, active-high segments and commons.
    run(2);  expect_out("gap_slot1",  8'h00, 1'b0, 1'b0, 2'b11);
    run(1);  expect_out("slot1_7",    8'h07, 1'b1, 1'b0, 2'b11);
    run(14); expect_out("gap_slot10", 8'h00, 1'b0, 1'b0, 2'b11);
    run(2);  expect_out("slot10_3",   8'h4F, 1'b0, 1'b1, 2'b11);
    run(14);

    // Same digits, both polarities inverted.
    seg_pol = 1'b0;
    com_pol = 1'b0;
    run(2);  expect_out("inv_slot1",  8'hF8, 1'b0, 1'b1, 2'b11);
    run(14);
    run(2);  expect_out("inv_slot10", 8'hB0, 1'b1, 1'b0, 2'b11);

    // Leading-zero blanking on a zero tens digit.
    seg_pol = 1'b1;
    com_pol = 1'b1;
    lzb     = 1'b1;
    digit10 = 4'd0;
    digit1  = 4'd5;
    run(13);
    run(3);  expect_out("lzb_slot1",  8'h6D, 1'b1, 1'b0, 2'b11);
    run(14);
    run(2);  expect_out("lzb_slot10", 8'h00, 1'b0, 1'b1, 2'b11);
    lzb = 1'b0;
    run(1);  expect_out("nolzb_slot10", 8'h3F, 1'b0, 1'b1, 2'b11);

    // Mid-slot input change must not tear the displayed digit.
    digit1 = 4'd2;
    run(13);
    run(3);  expect_out("snap_2",       8'h5B, 1'b1, 1'b0, 2'b11);
    digit1 = 4'd9;
    run(5);  expect_out("snap_hold",    8'h5B, 1'b1, 1'b0, 2'b11);
    run(9);
    run(16);
    run(2);  expect_out("snap_9",       8'h6F, 1'b1, 1'b0, 2'b11);

    // Enable dropped for 5 cycles in the middle of SLOT10.
    run(14);
    run(5);  expect_out("pre_dis",      8'h3F, 1'b0, 1'b1, 2'b11);
    ena = 1'b0;
    run(1);  expect_out("dis_first",    8'h00, 1'b0, 1'b0, 2'b00);
    run(4);  expect_out("dis_last",     8'h00, 1'b0, 1'b0, 2'b00);
    ena = 1'b1;
    run(2);  expect_out("resume_gap",   8'h00, 1'b0, 1'b0, 2'b11);
    run(1);  expect_out("resume_lit",   8'h3F, 1'b0, 1'b1, 2'b11);
    run(13); expect_out("resume_end",   8'h3F, 1'b0, 1'b1, 2'b11);
    run(1);  expect_out("resume_next",  8'h00, 1'b0, 1'b0, 2'b11);

    // Asynchronous reset in the middle of SLOT10.
    run(16);
    run(4);  expect_out("pre_rst",      8'h3F, 1'b0, 1'b1, 2'b11);
    rst_n = 1'b0;
    model_reset();
    #1;
    expect_out("async_rst", 8'h00, 1'b0, 1'b0, 2'b00);
    run(2);
    rst_n = 1'b1;
    run(2);  expect_out("post_rst_gap", 8'h00, 1'b0, 1'b0, 2'b11);
    run(1);  expect_out("post_rst_lit", 8'h6F, 1'b1, 1'b0, 2'b11);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) digit1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0)
        digit10 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) seg_pol = ~seg_pol;
      if ($urandom_range(0, 39) == 0) com_pol = ~com_pol;
      if ($urandom_range(0, 29) == 0) lzb = ~lzb;
      if (ena) begin
        if ($urandom_range(0, 59) == 0) ena = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) ena = 1'b1;
      end
      if (rst_n && $urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_model();
      end else if (!rst_n) begin
        rst_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_mux_driver.md
SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 Parameter SLOT_BITS, default 12: digit slot length is 2^SLOT_BITS clk cycles.
REQ-002 Parameter GAP_CYCLES, default 64: blanking cycles at the start of each slot; must be < 2^SLOT_BITS.
REQ-003 clk  in  1  system clock; the block uses only this clock.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ena  in  1  design enable; low freezes the sequencer and blanks the outputs.
REQ-006 digit1  in  4  ones digit, BCD; 15 = blank, 10..14 = blank.
REQ-007 digit10  in  4  tens digit, same coding as digit1.
REQ-008 seg_pol  in  1  segment polarity; 1 = segment lit when high.
REQ-009 com_pol  in  1  common polarity; 1 = digit active when common is high.
REQ-010 lzb  in  1  leading-zero blanking enable for digit10.
REQ-011 seg  out  8  segments, bit0=a .. bit6=g, bit7=dp (dp never lit).
REQ-012 com1  out  1  ones-digit common.
REQ-013 com10  out  1  tens-digit common.
REQ-014 com_oe  out  2  output enables, bit0=com1, bit1=com10.

Function
REQ-015 Sequencer states: SLOT1 and SLOT10 alternate; each lasts exactly 2^SLOT_BITS cycles, counted by a SLOT_BITS-bit counter that wraps to 0 on a state change.
REQ-016 While the counter is < GAP_CYCLES, both commons are inactive and seg is all-unlit (gap phase).
REQ-017 On the cycle the counter is 0, the slot's digit input is snapshotted; the snapshot is displayed for the rest of the slot, so input changes mid-slot do not tear.
REQ-018 After the gap, only the slot's common is active; the other common is inactive.
REQ-019 Lit patterns (a..g as bit0..6): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; codes 10..15 = 00.
REQ-020 If lzb=1 and the digit10 snapshot is 0, SLOT10 displays blank; its common is still driven active.
REQ-021 Output level = lit pattern XOR {8{~seg_pol}}; common = active XNOR com_pol, i.e. an active common equals com_pol.
REQ-022 seg, com1, com10 and com_oe are registered: the display state computed in cycle n appears on the outputs in cycle n+1; seg_pol/com_pol changes take effect after one cycle.
REQ-023 com_oe = 2'b11 from the first clock edge after reset release while ena=1; 2'b00 when ena=0.
REQ-024 ena=0: the counter and state hold, seg is all-unlit and commons inactive (at current polarity); on ena returning to 1 the slot resumes with a fresh gap phase, and the counter restarts at 0 with a new snapshot.
REQ-025 At no cycle are com1 and com10 both active.

Reset
REQ-026 While rst_n=0: state=SLOT1, counter=0, snapshots=15, seg=8'h00, com1=com10=0, com_oe=2'b00.
REQ-027 Reset asserted mid-slot takes effect immediately (asynchronous); release is followed by a full gap phase of SLOT1.

Structure
REQ-028 A shared package seg7_pkg holds the state enum, the 7-segment lookup constants and the blank code 4'd15.
REQ-029 One sub-module, seg7_decode (combinational BCD to a..g lookup), is instantiated once on the muxed snapshot.
REQ-030 Instantiated at top level with seg->uo_out, com1/com10->uio_out[3]/[4], seg_pol<-uio_in[6], com_pol<-uio_in[7].

Verification (SLOT_BITS=4, GAP_CYCLES=2 in the bench)
REQ-031 digit1=7, digit10=3, seg_pol=1, com_pol=1 -> SLOT1 shows seg=07 with com1=1, then SLOT10 shows 4F with com10=1; both commons are 0 for 2 cycles at each slot start.
REQ-032 Same digits with seg_pol=0, com_pol=0 -> seg=F8 in SLOT1 and B0 in SLOT10, and the active common is 0.
REQ-033 lzb=1, digit10=0, digit1=5 -> SLOT10 shows seg=00 with com10 active; SLOT1 shows 6D. With lzb=0, SLOT10 shows 3F.
REQ-034 digit1 changes from 2 to 9 mid-SLOT1 -> seg stays 5B until the next SLOT1 start, then shows 6F.
REQ-035 ena dropped for 5 cycles mid-SLOT10 -> com_oe=00, outputs unlit, counter frozen; after re-enable a 2-cycle gap occurs, then SLOT10 resumes for 16 cycles.
REQ-036 rst_n pulsed low mid-SLOT10 -> outputs go to the reset values without a clock edge; after release the sequence restarts at the SLOT1 gap; a bench assertion checks that com1 and com10 are never both active.
